// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: reset vector, NOP encoding and
// the fetch FSM state type.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam int unsigned BUF_DEPTH_DEFAULT = 2;
  localparam logic [31:0] NOP               = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    DROP  = 1'b1
  } fetch_state_t;

  // Sequential PC step; wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between fetch unit and memory.
interface inst_fetch_unit_if;
  logic        req;
  logic [31:0] adr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output adr, input ack, input rdata);
  modport slave  (input req, input adr, output ack, output rdata);
endinterface

// File: rtl/fetch_buffer.sv
// Two-entry prefetch FIFO holding {instruction, pc+4}; head is shown
// combinationally and reads as NOP/0 when empty.
module fetch_buffer
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [31:0] push_inst,
  input  logic [31:0] push_pc4,
  output logic [31:0] head_inst,
  output logic [31:0] head_pc4,
  output logic [1:0]  count
);

  logic [31:0] inst_mem [2];
  logic [31:0] pc4_mem  [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic        do_push;
  logic        do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else if (flush) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

  // Storage carries no reset; count alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      inst_mem[wr_ptr] <= push_inst;
      pc4_mem[wr_ptr]  <= push_pc4;
    end
  end

  assign head_inst = (count != 2'd0) ? inst_mem[rd_ptr] : NOP;
  assign head_pc4  = (count != 2'd0) ? pc4_mem[rd_ptr]  : 32'h0000_0000;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requests feeding a
// 2-entry prefetch buffer, with redirect handling via a FETCH/DROP FSM.
module inst_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned BUF_DEPTH = BUF_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  inst_fetch_unit_if.master        imem,
  input  logic                     redirect,
  input  logic [31:0]              redirect_adr,
  input  logic                     stall,
  output logic [31:0]              inst_out,
  output logic [31:0]              pc4_out,
  output logic                     inst_valid
);

  localparam logic [1:0] DEPTH = 2'(BUF_DEPTH);

  fetch_state_t state;
  logic [31:0]  fetch_pc;
  logic [31:0]  req_adr;
  logic         req;
  logic [1:0]   count;
  logic [1:0]   count_next;
  logic [31:0]  pc_next;
  logic         ack_ok;
  logic         hold;
  logic         do_push;
  logic         do_pop;

  // A late ack with no request raised is ignored.
  assign ack_ok  = req && imem.ack;
  assign hold    = req && !imem.ack;
  assign do_push = (state == FETCH) && ack_ok && !redirect;
  assign do_pop  = inst_valid && !stall && !redirect;

  always_comb begin
    count_next = count;
    if (redirect) count_next = 2'd0;
    else          count_next = count + 2'(do_push) - 2'(do_pop);
  end

  always_comb begin
    pc_next = fetch_pc;
    if (redirect)     pc_next = redirect_adr;
    else if (do_push) pc_next = pc_plus4(fetch_pc);
  end

  // req/req_adr only move on an ack edge or while idle, keeping the bus stable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      req      <= 1'b0;
      req_adr  <= RESET_PC;
    end else begin
      fetch_pc <= pc_next;
      case (state)
        FETCH: begin
          if (hold) begin
            if (redirect) state <= DROP;
          end else if (count_next < DEPTH) begin
            req     <= 1'b1;
            req_adr <= pc_next;
          end else begin
            req <= 1'b0;
          end
        end
        DROP: begin
          if (!hold) begin
            state   <= FETCH;
            req     <= 1'b1;
            req_adr <= pc_next;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign imem.req = req;
  assign imem.adr = req_adr;

  fetch_buffer u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (do_push),
    .pop       (do_pop),
    .flush     (redirect),
    .push_inst (imem.rdata),
    .push_pc4  (pc_plus4(fetch_pc)),
    .head_inst (inst_out),
    .head_pc4  (pc4_out),
    .count     (count)
  );

  assign inst_valid = (count != 2'd0);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios plus randomized stall/redirect
// and memory latency, checked against a queue-based reference model.
module tb_inst_fetch_unit;
  import mips_pkg::*;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc4;
  } ent_t;

  localparam logic [31:0] RPC  = 32'h0000_0000;
  localparam logic [31:0] RPC2 = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] redirect_adr = 32'h0;
  logic [31:0] inst_out, pc4_out;
  logic        inst_valid;
  logic [31:0] inst2, pc4_2;
  logic        valid2;

  int vecs = 0;
  int errs = 0;

  ent_t        mq[$];
  logic [31:0] m_pc, m_adr;
  logic        m_req, m_drop;
  int          lat_cfg, lat_left;
  bit          late_ack;
  logic [31:0] held;

  inst_fetch_unit_if imem ();
  inst_fetch_unit_if imem2 ();

  always #5 clk = ~clk;

  inst_fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem         (imem),
    .redirect     (redirect),
    .redirect_adr (redirect_adr),
    .stall        (stall),
    .inst_out     (inst_out),
    .pc4_out      (pc4_out),
    .inst_valid   (inst_valid)
  );

  // Second instance exercises a reset vector at the top of the address space.
  assign imem2.ack   = imem2.req;
  assign imem2.rdata = 32'h0000_0013;

  inst_fetch_unit #(.RESET_PC(RPC2), .BUF_DEPTH(2)) dut2 (
    .clk          (clk),
    .rst          (rst),
    .imem         (imem2),
    .redirect     (1'b0),
    .redirect_adr (32'h0),
    .stall        (1'b0),
    .inst_out     (inst2),
    .pc4_out      (pc4_2),
    .inst_valid   (valid2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [31:0] ei, ep;
    ei = 32'h0;
    ep = 32'h0;
    if (mq.size() != 0) begin
      ei = mq[0].inst;
      ep = mq[0].pc4;
    end
    chk("inst_valid", 32'(inst_valid), 32'(mq.size() != 0));
    chk("inst_out", inst_out, ei);
    chk("pc4_out", pc4_out, ep);
    chk("imem_req", 32'(imem.req), 32'(m_req));
    if (m_req) chk("imem_adr", imem.adr, m_adr);
  endtask

  // Drive one cycle's inputs and advance the model to the state after the next edge.
  task automatic drive(input logic s, input logic r, input logic [31:0] ra);
    logic        a, ack_ok, old_req;
    logic [31:0] d;
    ent_t        e;
    stall        = s;
    redirect     = r;
    redirect_adr = ra;
    a        = (m_req && lat_left == 0) || late_ack;
    late_ack = 0;
    d        = m_req ? mem_word(m_adr) : $urandom();
    imem.ack   = a;
    imem.rdata = d;
    old_req = m_req;
    ack_ok  = m_req && a;
    if (m_drop) begin
      if (r) m_pc = ra;
      if (ack_ok) begin
        m_drop = 0;
        m_req  = 1;
        m_adr  = m_pc;
      end
    end else if (r) begin
      mq.delete();
      m_pc = ra;
      if (m_req && !ack_ok) m_drop = 1;
      else begin
        m_req = 1;
        m_adr = m_pc;
      end
    end else begin
      if (mq.size() != 0 && !s) void'(mq.pop_front());
      if (ack_ok) begin
        e.inst = d;
        e.pc4  = m_adr + 32'd4;
        mq.push_back(e);
        m_pc = m_adr + 32'd4;
      end
      if (!m_req || ack_ok) begin
        m_req = (mq.size() < 2);
        if (m_req) m_adr = m_pc;
      end
    end
    if (m_req) begin
      if (!old_req || ack_ok)
        lat_left = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
      else if (lat_left > 0)
        lat_left--;
    end
  endtask

  task automatic cycle(input logic s, input logic r, input logic [31:0] ra);
    @(negedge clk);
    check_model();
    drive(s, r, ra);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst      = 1'b0;
    imem.ack = 1'b0;
    redirect = 1'b0;
    stall    = 1'b0;
    #1;
    chk("rst_req", 32'(imem.req), 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_inst", inst_out, NOP);
    chk("rst_pc4", pc4_out, 32'h0);
    mq.delete();
    m_pc     = RPC;
    m_adr    = RPC;
    m_req    = 0;
    m_drop   = 0;
    lat_left = 0;
    @(negedge clk);
    rst      = 1'b1;
    late_ack = 1;
    check_model();
    drive(1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    imem.ack   = 1'b0;
    imem.rdata = 32'h0;
    late_ack   = 0;

    // Zero-wait streaming from reset, and wrap-around reset vector on dut2.
    lat_cfg = 0;
    do_reset();
    cycle(0, 0, 0);
    chk("s035_adr0", imem.adr, 32'h0);
    chk("s039_adr_first", imem2.adr, RPC2);
    cycle(0, 0, 0);
    chk("s035_adr4", imem.adr, 32'h4);
    chk("s035_pc4_4", pc4_out, 32'h4);
    chk("s035_valid", 32'(inst_valid), 32'h1);
    chk("s039_pc4_wrap", pc4_2, 32'h0);
    chk("s039_adr_wrap", imem2.adr, 32'h0);
    chk("s039_inst", inst2, 32'h0000_0013);
    chk("s039_valid", 32'(valid2), 32'h1);
    cycle(0, 0, 0);
    chk("s035_adr8", imem.adr, 32'h8);
    chk("s035_pc4_8", pc4_out, 32'h8);

    // Stall with zero-wait memory: buffer fills, request drops, head holds.
    cycle(1, 0, 0);
    held = inst_out;
    cycle(1, 0, 0);
    chk("s036_req_drop", 32'(imem.req), 32'h0);
    chk("s036_hold", inst_out, held);
    cycle(1, 0, 0);
    chk("s036_hold2", inst_out, held);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0);

    // Redirect while a 3-cycle request is in flight.
    lat_cfg = 2;
    do_reset();
    for (int i = 0; i < 40 && !(m_req && m_adr == 32'h8); i++) cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("s037_adr8", imem.adr, 32'h8);
    cycle(0, 1, 32'h100);
    cycle(0, 0, 0);
    chk("s037_drop_hold", imem.adr, 32'h8);
    cycle(0, 0, 0);
    chk("s037_adr100", imem.adr, 32'h100);
    chk("s037_novalid", 32'(inst_valid), 32'h0);
    for (int i = 0; i < 10 && inst_valid !== 1'b1; i++) cycle(0, 0, 0);
    chk("s037_pc4", pc4_out, 32'h104);

    // Redirect coinciding with an ack, then redirect with a full buffer.
    lat_cfg = 0;
    do_reset();
    cycle(1, 0, 0);
    cycle(1, 1, 32'h40);
    chk("s038_pre_valid", 32'(inst_valid), 32'h1);
    cycle(0, 0, 0);
    chk("s038_valid", 32'(inst_valid), 32'h0);
    chk("s038_adr", imem.adr, 32'h40);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(1, 1, 32'h80);
    chk("s038_full_valid", 32'(inst_valid), 32'h1);
    cycle(0, 0, 0);
    chk("s038_full_flush", 32'(inst_valid), 32'h0);
    chk("s038_full_adr", imem.adr, 32'h80);

    // Reset while a request is outstanding and the buffer is occupied.
    lat_cfg = 3;
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1, 0, 0);
    chk("s040_pre_valid", 32'(inst_valid), 32'h1);
    do_reset();
    cycle(0, 0, 0);
    chk("s040_adr", imem.adr, RPC);

    // Randomized traffic with variable latency, stalls and redirects.
    lat_cfg = -1;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic        s, r;
      logic [31:0] ra;
      if (i == 200) do_reset();
      s  = ($urandom_range(0, 9) < 3);
      r  = ($urandom_range(0, 15) == 0);
      ra = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if ($urandom_range(0, 3) == 0) ra = 32'hFFFF_FFF8;
      cycle(s, r, ra);
    end
    cycle(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, prefetch buffer entries; fixed at 2 for this revision.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 imem_req  output  1  instruction memory request.
REQ-006 imem_adr  output  32  word-aligned fetch address; valid while imem_req=1.
REQ-007 imem_ack  input  1  memory return strobe; imem_rdata valid in the same cycle.
REQ-008 imem_rdata  input  32  fetched instruction.
REQ-009 redirect  input  1  branch/jump/jr taken; restart fetch at redirect_adr.
REQ-010 redirect_adr  input  32  new fetch target.
REQ-011 stall  input  1  downstream IF/ID register is not accepting this cycle.
REQ-012 inst_out  output  32  instruction presented to the IF/ID register.
REQ-013 pc4_out  output  32  address of inst_out plus 4.
REQ-014 inst_valid  output  1  inst_out/pc4_out hold a real instruction.

Function
REQ-015 Memory handshake: once imem_req rises, imem_req and imem_adr SHALL hold stable until the edge where imem_ack=1; imem_ack may arrive in the same cycle imem_req rises (zero-wait memory).
REQ-016 At most one request SHALL be outstanding at any time.
REQ-017 A new request SHALL be raised only in state FETCH with buffer count < BUF_DEPTH; count SHALL never exceed BUF_DEPTH.
REQ-018 On an accepted ack in FETCH, {imem_rdata, fetch_pc+4} SHALL be written to the buffer and fetch_pc SHALL advance by 4 at that edge.
REQ-019 Buffer SHALL be FIFO; the head drives inst_out/pc4_out combinationally; inst_valid = (count != 0).
REQ-020 Empty buffer: inst_out SHALL be 32'h0000_0000 (NOP), pc4_out 0, inst_valid 0.
REQ-021 Pop SHALL occur on an edge with inst_valid=1 and stall=0; push and pop in the same edge SHALL leave count unchanged.
REQ-022 Latency: ack at edge N SHALL make that instruction visible on inst_out after edge N when the buffer was empty; sustained throughput with zero-wait memory and stall=0 SHALL be one instruction per cycle.
REQ-023 FSM states: FETCH, DROP.
REQ-024 FETCH + redirect with no request outstanding, or with ack in the same cycle: flush buffer, fetch_pc <= redirect_adr, remain in FETCH, discard any acked data.
REQ-025 FETCH + redirect with request outstanding and no ack: flush buffer, fetch_pc <= redirect_adr, go to DROP.
REQ-026 DROP: imem_req held with old address; on ack, data SHALL be discarded and the state SHALL return to FETCH; the next request SHALL use redirect_adr.
REQ-027 DROP + another redirect: fetch_pc SHALL update to the newest redirect_adr; state SHALL remain DROP.
REQ-028 redirect SHALL take priority over stall and over pop; buffer contents SHALL never survive a redirect edge.
REQ-029 Arithmetic: fetch_pc+4 SHALL be 32-bit modulo; 32'hFFFF_FFFC wraps to 0.

Reset
REQ-030 While rst=0 asynchronously: fetch_pc=RESET_PC, count=0, state=FETCH, imem_req=0, inst_valid=0, inst_out=0, pc4_out=0.
REQ-031 The first cycle after rst deasserts SHALL raise imem_req with imem_adr=RESET_PC.
REQ-032 Reset mid-request SHALL abandon the request; a late ack after reset SHALL be ignored if imem_req=0.

Structure
REQ-033 Package mips_pkg SHALL hold the default RESET_PC, the NOP constant, and the fetch FSM state enum.
REQ-034 Sub-module fetch_buffer (2-entry FIFO with push, pop, flush, count) SHALL hold the buffer storage; the FSM and PC logic stay in inst_fetch_unit.

Verification
REQ-035 Reset release, zero-wait ack, stall=0 -> imem_adr 0,4,8,... on consecutive cycles; inst_valid high from the 2nd cycle; pc4_out 4,8,12.
REQ-036 stall=1 for 3 cycles, zero-wait memory -> count reaches 2, imem_req drops, inst_out constant; on release, fetch resumes with no lost or duplicated instruction.
REQ-037 3-cycle memory latency, redirect to 32'h100 one cycle after req at 32'h8 -> DROP entered, ack data for 8 discarded, next imem_adr=32'h100, first valid pc4_out=32'h104.
REQ-038 redirect to 32'h40 with ack in the same cycle and buffer holding 2 entries -> buffer emptied, inst_valid=0 next cycle, next imem_adr=32'h40.
REQ-039 RESET_PC=32'hFFFF_FFFC -> first pc4_out=0, next imem_adr=0.
REQ-040 rst asserted while req outstanding and buffer non-empty -> all outputs 0 immediately; after release, imem_adr=RESET_PC.
